// File: rtl/tow_core_n_if.sv
// tow_core_n_if: button, tick and display signals of the tug-of-war core
interface tow_core_n_if #(parameter int NLED = 7);
  logic pbl, pbr, slowen, new_game;
  logic leds_on, winrnd, rnd_winner, victory, victor;
  logic [NLED-1:0] led;
  logic [7:0] rounds;
  modport master (output pbl, pbr, slowen, new_game,
                  input led, leds_on, winrnd, rnd_winner, victory, victor, rounds);
  modport slave (input pbl, pbr, slowen, new_game,
                 output led, leds_on, winrnd, rnd_winner, victory, victor, rounds);
endinterface

// File: rtl/tow_core_n.sv
// tow_core_n: two-button reaction tug-of-war with random arm delay and LED bar
module tow_core_n #(
  parameter int NLED = 7,
  parameter int DELAY_W = 4,
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT = 64,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic rst,
  tow_core_n_if.slave bus
);
  localparam int PW = $clog2(NLED);
  localparam int CW = $clog2(MIN_WAIT + 2**DELAY_W + TIMEOUT + 1);
  localparam logic [PW-1:0] C = PW'((NLED - 1) / 2);
  localparam logic [PW-1:0] TOP = PW'(NLED - 1);
  typedef enum logic [2:0] {RELEASE, WAIT, ARMED, RESOLVE, VICTORY} state_t;
  state_t state, nxt;
  logic [15:0] lfsr;
  logic [PW-1:0] pos;
  logic [CW-1:0] cnt, cnt_nxt;
  logic pbl_q, pbr_q, blink, go, win, who, el, er;
  assign el = bus.pbl & ~pbl_q;
  assign er = bus.pbr & ~pbr_q;
  assign bus.leds_on = state == ARMED;
  assign bus.victory = state == VICTORY;
  assign bus.led = state == VICTORY ? {NLED{blink}} : {{(NLED-1){1'b0}}, 1'b1} << pos;
  // who = 1 means the right player takes the round; a false start hands it to the opponent
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    go = 1'b0;
    win = 1'b0;
    who = 1'b0;
    case (state)
      RELEASE: if (!bus.pbl && !bus.pbr) begin
        nxt = WAIT;
        cnt_nxt = CW'(MIN_WAIT) + CW'(lfsr[DELAY_W-1:0]);
      end
      WAIT: if (el || er) begin
        go = 1'b1;
        win = el ^ er;
        who = el;
      end else if (cnt == '0) begin
        nxt = ARMED;
        cnt_nxt = CW'(TIMEOUT);
      end else if (bus.slowen) cnt_nxt = cnt - 1'b1;
      ARMED: if (el || er) begin
        go = 1'b1;
        win = el ^ er;
        who = er;
      end else if (bus.slowen) begin
        go = cnt <= CW'(1);
        cnt_nxt = cnt - 1'b1;
      end
      RESOLVE: nxt = (pos == '0 || pos == TOP) ? VICTORY : RELEASE;
      VICTORY: if (bus.new_game) nxt = RELEASE;
      default: nxt = RELEASE;
    endcase
    if (go) nxt = RESOLVE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RELEASE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos <= C;
      cnt <= '0;
      lfsr <= SEED;
      pbl_q <= 1'b0;
      pbr_q <= 1'b0;
      blink <= 1'b0;
      bus.winrnd <= 1'b0;
      bus.rnd_winner <= 1'b0;
      bus.victor <= 1'b0;
      bus.rounds <= '0;
    end else begin
      cnt <= cnt_nxt;
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      pbl_q <= bus.pbl;
      pbr_q <= bus.pbr;
      bus.winrnd <= go && win;
      if (go && win) bus.rnd_winner <= who;
      if (go && win) pos <= who ? (pos != '0 ? pos - 1'b1 : pos) : (pos != TOP ? pos + 1'b1 : pos);
      if (go && bus.rounds != 8'hFF) bus.rounds <= bus.rounds + 8'd1;
      if (state == RESOLVE && nxt == VICTORY) begin
        blink <= 1'b1;
        bus.victor <= pos != TOP;
      end else if (state == VICTORY && bus.slowen) blink <= ~blink;
      if (state == VICTORY && bus.new_game) begin
        pos <= C;
        bus.rounds <= '0;
        bus.victor <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_tow_core_n.sv
// tb_tow_core_n: directed plus random games checked against a round-level game model
module tb_tow_core_n;
  localparam int NLED = 7;
  localparam int C = (NLED - 1) / 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int m_pos = C;
  int m_rounds = 0;
  bit m_vic = 0;
  bit m_rw = 0;
  tow_core_n_if #(.NLED(NLED)) bus ();
  tow_core_n #(.NLED(NLED)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go_wait();
    bus.pbl = 0; bus.pbr = 0; bus.slowen = 0;
    tick();
    tick();
  endtask
  task automatic arm();
    int n = 0;
    bus.slowen = 1;
    while (!bus.leds_on && n < 60) begin
      tick();
      n++;
    end
    bus.slowen = 0;
    chk("armed", bus.leds_on, 1);
  endtask
  // armed: left button pulls toward high index; false start: the other player wins
  task automatic press(input bit bl, input bit br, input bit armed);
    bit w, who;
    w = bl ^ br;
    who = armed ? br : bl;
    bus.pbl = bl; bus.pbr = br; bus.slowen = 0;
    tick();
    if (w) begin
      m_pos = who ? m_pos - 1 : m_pos + 1;
      m_rw = who;
    end
    if (m_rounds < 255) m_rounds++;
    chk("winrnd", bus.winrnd, w);
    chk("rnd_winner", bus.rnd_winner, m_rw);
    chk("led_resolve", bus.led, 1 << m_pos);
    chk("rounds", bus.rounds, m_rounds);
    chk("leds_on_resolve", bus.leds_on, 0);
    bus.pbl = 0; bus.pbr = 0;
    tick();
    m_vic = m_pos == 0 || m_pos == NLED - 1;
    chk("winrnd_pulse", bus.winrnd, 0);
    chk("victory", bus.victory, m_vic);
    if (m_vic) begin
      chk("victor", bus.victor, m_pos == 0);
      chk("led_victory", bus.led, 7'h7F);
    end
  endtask
  task automatic finish_game();
    int r;
    bus.slowen = 1;
    tick();
    chk("blink_off", bus.led, 7'h00);
    tick();
    chk("blink_on", bus.led, 7'h7F);
    bus.slowen = 0;
    r = m_rounds;
    bus.pbr = 1;
    tick();
    bus.pbr = 0;
    tick();
    chk("victory_press_rounds", bus.rounds, r);
    chk("victory_press_winrnd", bus.winrnd, 0);
    chk("victory_held", bus.victory, 1);
    bus.new_game = 1;
    tick();
    bus.new_game = 0;
    m_pos = C; m_rounds = 0; m_vic = 0;
    chk("ng_led", bus.led, 1 << C);
    chk("ng_victory", bus.victory, 0);
    chk("ng_victor", bus.victor, 0);
    chk("ng_rounds", bus.rounds, 0);
  endtask
  initial begin
    int r, n;
    bus.pbl = 0; bus.pbr = 0; bus.slowen = 0; bus.new_game = 0;
    tick();
    tick();
    chk("rst_led", bus.led, 7'b0001000);
    chk("rst_leds_on", bus.leds_on, 0);
    chk("rst_victory", bus.victory, 0);
    chk("rst_rounds", bus.rounds, 0);
    rst = 1;
    go_wait(); arm(); press(1, 0, 1);
    chk("req034_led", bus.led, 7'b0010000);
    go_wait(); press(0, 1, 0);
    go_wait(); arm(); press(1, 1, 1);
    go_wait();
    bus.new_game = 1;
    tick();
    bus.new_game = 0;
    chk("ng_ignored_rounds", bus.rounds, m_rounds);
    chk("ng_ignored_led", bus.led, 1 << m_pos);
    arm();
    for (int i = 0; i < 63; i++) begin
      bus.slowen = 1; tick(); bus.slowen = 0; tick();
    end
    chk("timeout_not_yet", bus.leds_on, 1);
    bus.slowen = 1;
    tick();
    bus.slowen = 0;
    m_rounds++;
    chk("timeout_winrnd", bus.winrnd, 0);
    chk("timeout_rounds", bus.rounds, m_rounds);
    chk("timeout_led", bus.led, 1 << m_pos);
    tick();
    chk("timeout_release", bus.leds_on, 0);
    go_wait(); arm();
    bus.pbr = 1;
    tick();
    m_pos--; m_rw = 1; m_rounds++;
    chk("hold_winrnd", bus.winrnd, 1);
    chk("hold_led", bus.led, 1 << m_pos);
    bus.slowen = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("hold_leds_on", bus.leds_on, 0);
    end
    chk("hold_rounds", bus.rounds, m_rounds);
    go_wait(); arm();
    rst = 0;
    #1;
    m_pos = C; m_rounds = 0; m_rw = 0;
    chk("arst_led", bus.led, 7'b0001000);
    chk("arst_leds_on", bus.leds_on, 0);
    chk("arst_winrnd", bus.winrnd, 0);
    chk("arst_rnd_winner", bus.rnd_winner, 0);
    chk("arst_victory", bus.victory, 0);
    chk("arst_victor", bus.victor, 0);
    chk("arst_rounds", bus.rounds, 0);
    tick();
    chk("arst_no_winrnd", bus.winrnd, 0);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      go_wait(); arm(); press(0, 1, 1);
    end
    chk("right_victor", bus.victor, 1);
    finish_game();
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (!m_vic && n < 60) begin
        r = $urandom_range(0, 5);
        go_wait();
        if (r < 3) arm();
        press(r % 3 != 1, r % 3 != 0, r < 3);
        n++;
      end
      chk("random_game_ends", m_vic, 1);
      finish_game();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
